// File: rtl/regfile_write_port_if.sv
// Write-request and read-out bundle for the 32 x 32-bit register file write port.
// Request side: a write is accepted at a rising edge where ctrl_writeEnable and write_ready are both 1;
// write_ready never depends combinationally on the request inputs.
interface regfile_write_port_if #(
  parameter int QDEPTH = 2
);
  logic                            ctrl_writeEnable;
  logic [4:0]                      ctrl_writeReg;
  logic [31:0]                     data_writeReg;
  logic                            ctrl_hold;
  logic                            write_ready;
  logic [1023:0]                   Q;
  logic [31:0]                     we_onehot;
  logic                            commit_valid;
  logic [$clog2(QDEPTH+1)-1:0]     pending_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_hold,
    input  write_ready, Q, we_onehot, commit_valid, pending_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_hold,
    output write_ready, Q, we_onehot, commit_valid, pending_count
  );
endinterface

// File: rtl/regfile_write_port.sv
// Write side of a 32 x 32-bit register file: in-order pending-write queue feeding
// one commit per cycle, register 0 hardwired to zero, ctrl_hold freezes commits.
module regfile_write_port #(
  parameter int QDEPTH = 2
) (
  input logic               clock,
  input logic               ctrl_reset_n,
  regfile_write_port_if.slave wr
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [4:0]    q_idx  [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   regs [1:31];

  logic          ready;
  logic          push;
  logic          pop;
  logic [1023:0] q_flat;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at occupancy, so a full queue refuses even while draining.
  assign ready = (count < CW'(QDEPTH));
  assign pop   = (count != '0) && !wr.ctrl_hold;
  assign push  = wr.ctrl_writeEnable && ready && (wr.ctrl_writeReg != 5'd0);

  assign wr.write_ready   = ready;
  assign wr.commit_valid  = pop;
  assign wr.pending_count = count;
  assign wr.we_onehot     = pop ? (32'd1 << q_idx[head]) : 32'd0;
  assign wr.Q             = q_flat;

  always_comb begin
    q_flat = '0;
    for (int i = 1; i < 32; i++) begin
      q_flat[32*i +: 32] = regs[i];
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        q_idx[i]  <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_idx[tail]  <= wr.ctrl_writeReg;
        q_data[tail] <= wr.data_writeReg;
        tail         <= next_ptr(tail);
      end
      // Queued indices are never zero, so the head always targets regs[1..31].
      if (pop) begin
        regs[q_idx[head]] <= q_data[head];
        head              <= next_ptr(head);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port using a queue-based reference model.
module tb_regfile_write_port;
  localparam int QD = 2;
  localparam int CW = $clog2(QD + 1);

  logic clock;
  logic ctrl_reset_n;

  regfile_write_port_if #(.QDEPTH(QD)) bus ();

  regfile_write_port #(.QDEPTH(QD)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .wr           (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model: committed registers plus a FIFO of pending writes
  logic [31:0] m_regs [32];
  logic [4:0]  mq_idx  [$];
  logic [31:0] mq_data [$];
  logic [4:0]  exp_q [$];

  logic          obs_ready, obs_cv, exp_ready, exp_cv;
  logic [31:0]   obs_oh, exp_oh;
  logic [CW-1:0] obs_cnt, exp_cnt;
  logic [1023:0] obs_q, exp_qv;

  function automatic logic [1023:0] model_q();
    logic [1023:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[32*i +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    mq_idx.delete();
    mq_data.delete();
  endfunction

  // Call just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input logic we, input logic [4:0] idx, input logic [31:0] data,
                             input logic hold, output logic acc);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = idx;
    bus.data_writeReg    = data;
    bus.ctrl_hold        = hold;
    #1;
    obs_ready = bus.write_ready;
    obs_cv    = bus.commit_valid;
    obs_oh    = bus.we_onehot;
    obs_cnt   = bus.pending_count;
    obs_q     = bus.Q;
    exp_ready = mq_idx.size() < QD;
    exp_cv    = (mq_idx.size() != 0) && !hold;
    exp_oh    = exp_cv ? (32'd1 << mq_idx[0]) : 32'd0;
    exp_cnt   = CW'(mq_idx.size());
    exp_qv    = model_q();
    acc       = we && exp_ready;
    @(posedge clock);
    if (exp_cv) begin
      m_regs[mq_idx[0]] = mq_data[0];
      void'(mq_idx.pop_front());
      void'(mq_data.pop_front());
    end
    if (acc && idx != 5'd0) begin
      mq_idx.push_back(idx);
      mq_data.push_back(data);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic acc;
    ctrl_reset_n = 1'b0;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd4;
    bus.data_writeReg    = 32'h44;
    bus.ctrl_hold        = 1'b0;
    @(posedge clock);
    #1;
    total++; if (bus.write_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.write_ready); end
    total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b want=0", bus.commit_valid); end
    total++; if (bus.we_onehot !== 32'd0) begin bad++; $display("FAIL reset_onehot got=%h want=0", bus.we_onehot); end
    total++; if (bus.pending_count !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.pending_count); end
    total++; if (bus.Q !== '0) begin bad++; $display("FAIL reset_q nonzero"); end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    model_clear();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
    total++; if (obs_cnt !== '0 || obs_cv !== 1'b0) begin bad++; $display("FAIL reset_ignored cnt=%0d cv=%b want 0/0", obs_cnt, obs_cv); end
  endtask

  task automatic test_single_write();
    logic acc;
    drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, acc);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", obs_ready); end
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
    total++; if (obs_cv !== 1'b1) begin bad++; $display("FAIL single_cv got=%b want=1", obs_cv); end
    total++; if (obs_oh !== 32'h0000_0020) begin bad++; $display("FAIL single_onehot got=%h want=00000020", obs_oh); end
    total++; if (bus.Q[191:160] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_q got=%h want=deadbeef", bus.Q[191:160]); end
    total++; if (bus.pending_count !== '0) begin bad++; $display("FAIL single_cnt got=%0d want=0", bus.pending_count); end
  endtask

  task automatic test_reg0();
    logic acc;
    drive_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, acc);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL reg0_ready got=%b want=1", obs_ready); end
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
      total++; if (obs_cnt !== '0) begin bad++; $display("FAIL reg0_cnt got=%0d want=0", obs_cnt); end
      total++; if (obs_oh[0] !== 1'b0 || obs_cv !== 1'b0) begin bad++; $display("FAIL reg0_commit oh=%h cv=%b want 0/0", obs_oh, obs_cv); end
    end
    total++; if (bus.Q[31:0] !== 32'd0) begin bad++; $display("FAIL reg0_q got=%h want=0", bus.Q[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int peak;
    peak = 0;
    for (int v = 1; v <= 3; v++) begin
      drive_cycle(1'b1, 5'd3, 32'(v), 1'b0, acc);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready v=%0d got=%b want=1", v, obs_ready); end
      if (int'(obs_cnt) > peak) peak = int'(obs_cnt);
    end
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
    if (int'(obs_cnt) > peak) peak = int'(obs_cnt);
    total++; if (peak != 1) begin bad++; $display("FAIL b2b_peak got=%0d want=1", peak); end
    total++; if (bus.Q[127:96] !== 32'd3) begin bad++; $display("FAIL b2b_q got=%h want=3", bus.Q[127:96]); end
  endtask

  task automatic test_hold_fill();
    logic acc;
    logic got9;
    int order[$];
    drive_cycle(1'b1, 5'd7, 32'hA, 1'b1, acc);
    drive_cycle(1'b1, 5'd8, 32'hB, 1'b1, acc);
    drive_cycle(1'b1, 5'd9, 32'hC, 1'b1, acc);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", obs_ready); end
    total++; if (obs_cnt !== CW'(2)) begin bad++; $display("FAIL fill_cnt got=%0d want=2", obs_cnt); end
    got9 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(!got9, 5'd9, 32'hC, 1'b0, acc);
      if (c == 0) begin
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL release_ready got=%b want=0", obs_ready); end
      end
      if (acc) got9 = 1'b1;
      if (obs_cv === 1'b1) order.push_back($clog2(obs_oh));
    end
    total++; if (order.size() != 3) begin bad++; $display("FAIL hold_order_len got=%0d want=3", order.size()); end
    else begin
      total++; if (order[0] != 7 || order[1] != 8 || order[2] != 9) begin
        bad++; $display("FAIL hold_order got=%0d,%0d,%0d want=7,8,9", order[0], order[1], order[2]);
      end
    end
    total++; if (bus.Q[32*9 +: 32] !== 32'hC || bus.Q[32*8 +: 32] !== 32'hB || bus.Q[32*7 +: 32] !== 32'hA) begin
      bad++; $display("FAIL hold_q got=%h,%h,%h want=a,b,c", bus.Q[32*7 +: 32], bus.Q[32*8 +: 32], bus.Q[32*9 +: 32]);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    drive_cycle(1'b1, 5'd10, 32'h1010, 1'b1, acc);
    drive_cycle(1'b1, 5'd11, 32'h1111, 1'b1, acc);
    total++; if (bus.pending_count !== CW'(2)) begin bad++; $display("FAIL mid_prefill got=%0d want=2", bus.pending_count); end
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_hold        = 1'b0;
    #2 ctrl_reset_n = 1'b0;
    #1;
    total++; if (bus.Q !== '0) begin bad++; $display("FAIL mid_q nonzero during reset"); end
    total++; if (bus.pending_count !== '0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", bus.pending_count); end
    total++; if (bus.write_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", bus.write_ready); end
    ctrl_reset_n = 1'b1;
    model_clear();
    @(negedge clock);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, acc);
      total++; if (obs_cv !== 1'b0 || obs_oh !== 32'd0) begin bad++; $display("FAIL mid_commit cv=%b oh=%h want 0/0", obs_cv, obs_oh); end
    end
    total++; if (bus.Q !== '0) begin bad++; $display("FAIL mid_after_q nonzero"); end
  endtask

  task automatic test_wrap();
    logic acc;
    int i;
    int cyc;
    exp_q.delete();
    i = 1;
    cyc = 0;
    while ((i <= 20 || exp_q.size() != 0) && cyc < 400) begin
      drive_cycle(i <= 20, 5'(i), 32'(i), cyc[0], acc);
      if (obs_cv === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL wrap_extra_commit oh=%h", obs_oh); end
        else begin
          if (obs_oh !== (32'd1 << exp_q[0])) begin bad++; $display("FAIL wrap_order got=%h want=%h", obs_oh, 32'd1 << exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        exp_q.push_back(5'(i));
        i++;
      end
      cyc++;
    end
    total++; if (cyc >= 400) begin bad++; $display("FAIL wrap_timeout cycles=%0d limit=400", cyc); end
    for (int r = 1; r <= 20; r++) begin
      total++; if (bus.Q[32*r +: 32] !== 32'(r)) begin bad++; $display("FAIL wrap_reg%0d got=%h want=%h", r, bus.Q[32*r +: 32], r); end
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int c = 0; c < 300; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) == 0, acc);
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      total++; if (obs_cv !== exp_cv) begin bad++; $display("FAIL rand_cv c=%0d got=%b want=%b", c, obs_cv, exp_cv); end
      total++; if (obs_oh !== exp_oh) begin bad++; $display("FAIL rand_onehot c=%0d got=%h want=%h", c, obs_oh, exp_oh); end
      total++; if (obs_cnt !== exp_cnt) begin bad++; $display("FAIL rand_cnt c=%0d got=%0d want=%0d", c, obs_cnt, exp_cnt); end
      total++; if (obs_q !== exp_qv) begin bad++; $display("FAIL rand_q c=%0d differs from model", c); end
    end
  endtask

  initial begin
    ctrl_reset_n         = 1'b0;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'd0;
    bus.ctrl_hold        = 1'b0;
    model_clear();
    @(negedge clock);
    test_reset();
    test_single_write();
    test_reg0();
    test_back_to_back();
    test_hold_fill();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
